// File: rtl/motor_pwm_phase_dt.sv
// Single-phase complementary PWM with dead-time insertion for one half-bridge.
// Ports: iCLK clock, iENABLE async active-low reset/enable, iPERIOD/iDUTY/
//   iDEADBAND/iCOUNTER SIZE-bit control inputs, oPAD_P/oPAD_N registered gates.
module motor_pwm_phase_dt #(
   parameter int SIZE = 16
) (
   input  logic            iCLK,
   input  logic            iENABLE,
   input  logic [SIZE-1:0] iPERIOD,
   input  logic [SIZE-1:0] iDUTY,
   input  logic [SIZE-1:0] iDEADBAND,
   input  logic [SIZE-1:0] iCOUNTER,
   output logic            oPAD_P,
   output logic            oPAD_N
);

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2,
      ST_DEAD = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [SIZE-1:0] r_dead;
   logic [SIZE-1:0] w_dead_next;
   logic            w_demand;
   logic            w_db_zero;
   logic            r_pad_p;
   logic            r_pad_n;

   // A counter above the period (incl. the all-ones idle value) never demands.
   assign w_demand  = (iCOUNTER < iDUTY) && (iCOUNTER <= iPERIOD);
   assign w_db_zero = (iDEADBAND == '0);

   always_comb begin
      w_next      = r_state;
      w_dead_next = r_dead;
      unique case (r_state)
         ST_OFF: begin
            if (w_db_zero) begin
               w_next = w_demand ? ST_HIGH : ST_LOW;
            end else begin
               w_next      = ST_DEAD;
               w_dead_next = SIZE'(1);
            end
         end
         ST_HIGH: begin
            if (!w_demand) begin
               if (w_db_zero) begin
                  w_next = ST_LOW;
               end else begin
                  w_next      = ST_DEAD;
                  w_dead_next = SIZE'(1);
               end
            end
         end
         ST_LOW: begin
            if (w_demand) begin
               if (w_db_zero) begin
                  w_next = ST_HIGH;
               end else begin
                  w_next      = ST_DEAD;
                  w_dead_next = SIZE'(1);
               end
            end
         end
         ST_DEAD: begin
            // r_dead counts low cycles already elapsed; exit side is the
            // demand at expiry, not the side that turned off.
            if (r_dead >= iDEADBAND) begin
               w_next = w_demand ? ST_HIGH : ST_LOW;
            end else if (r_dead != '1) begin
               w_dead_next = r_dead + SIZE'(1);
            end
         end
         default: begin
            w_next = ST_OFF;
         end
      endcase
   end

   always_ff @(posedge iCLK or negedge iENABLE) begin
      if (!iENABLE) begin
         r_state <= ST_OFF;
         r_dead  <= '0;
         r_pad_p <= 1'b0;
         r_pad_n <= 1'b0;
      end else begin
         r_state <= w_next;
         r_dead  <= w_dead_next;
         // Pads are flops decoded from the next state so they never glitch.
         r_pad_p <= (w_next == ST_HIGH);
         r_pad_n <= (w_next == ST_LOW);
      end
   end

   assign oPAD_P = r_pad_p;
   assign oPAD_N = r_pad_n;

endmodule

// File: tb/tb_motor_pwm_phase_dt.sv
// Self-checking bench for motor_pwm_phase_dt: directed steps plus a random
// run compared against a side/gap reference model and a dead-gap monitor.
module tb_motor_pwm_phase_dt;

   logic        clk = 1'b0;
   logic        en;
   logic [15:0] per, duty, db, cnt;
   logic        p, n;

   always #5 clk = ~clk;

   motor_pwm_phase_dt #(.SIZE(16)) dut (
      .iCLK      (clk),
      .iENABLE   (en),
      .iPERIOD   (per),
      .iDUTY     (duty),
      .iDEADBAND (db),
      .iCOUNTER  (cnt),
      .oPAD_P    (p),
      .oPAD_N    (n)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Model: which side conducts (0 none, 1 high, 2 low), whether we are in
   // the start-up idle, and how many all-low cycles have elapsed in a gap.
   int  m_side;
   bit  m_fresh;
   int  m_gap;
   int  lowrun;
   logic pp, pn;
   bit  hold;

   logic pr [100];
   logic nr [100];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic mreset();
      m_side  = 0;
      m_fresh = 1;
      m_gap   = 0;
   endtask

   task automatic tick();
      bit d;
      int want;
      @(posedge clk);
      #1;
      if (en) begin
         d    = (cnt < duty) && (cnt <= per);
         want = d ? 1 : 2;
         if (m_side == 0) begin
            if (m_fresh) begin
               m_fresh = 0;
               if (db == 0) m_side = want;
               else m_gap = 1;
            end else if (m_gap >= int'(db)) begin
               m_side = want;
            end else if (m_gap < 65535) begin
               m_gap++;
            end
         end else if (m_side != want) begin
            if (db == 0) m_side = want;
            else begin
               m_side = 0;
               m_gap  = 1;
            end
         end
      end
      chk("pad_p", 32'(p), 32'(m_side == 1));
      chk("pad_n", 32'(n), 32'(m_side == 2));
      chk("overlap", 32'(p & n), 0);
      if ((p && !pp) || (n && !pn))
         chk("dead_gap", 32'(lowrun >= int'(db)), 1);
      lowrun = (p || n) ? 0 : lowrun + 1;
      pp = p;
      pn = n;
      if (!hold) cnt = (cnt >= per) ? 16'd0 : cnt + 16'd1;
   endtask

   task automatic run(input int k);
      for (int i = 0; i < k; i++) tick();
   endtask

   task automatic disable_pulse();
      en = 1'b0;
      #1;
      chk("async_off_p", 32'(p), 0);
      chk("async_off_n", 32'(n), 0);
      mreset();
      lowrun = 0;
      pp = 1'b0;
      pn = 1'b0;
      en = 1'b1;
   endtask

   initial begin
      int cp, cn, s;
      en = 1'b0; per = 16'd9; duty = 16'd5; db = 16'd3; cnt = 16'd0;
      hold = 1; mreset(); lowrun = 0; pp = 1'b0; pn = 1'b0;

      #12;
      chk("reset_p", 32'(p), 0);
      chk("reset_n", 32'(n), 0);
      run(2);

      // Start-up dead time of 3, then high side.
      en = 1'b1;
      tick(); chk("start_e1_p", 32'(p), 0);
      tick(); chk("start_e2_p", 32'(p), 0);
      tick(); chk("start_e3_p", 32'(p), 0);
      tick(); chk("start_e4_p", 32'(p), 1);
      chk("start_e4_n", 32'(n), 0);

      // Disable while high: pads drop without a clock.
      #3;
      disable_pulse();

      // Steady PWM, no dead time.
      per = 16'd9; duty = 16'd4; db = 16'd0; cnt = 16'd0; hold = 0;
      run(20);
      cp = 0; cn = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         cp += int'(p);
         cn += int'(n);
      end
      chk("pwm_p_count", 32'(cp), 8);
      chk("pwm_n_count", 32'(cn), 12);

      // Dead time 5 around both transitions.
      per = 16'd99; duty = 16'd50; db = 16'd5; cnt = 16'd0;
      run(200);
      for (int i = 0; i < 100; i++) begin
         s = int'(cnt);
         tick();
         pr[s] = p;
         nr[s] = n;
      end
      chk("db_p_at49", 32'(pr[49]), 1);
      chk("db_p_at50", 32'(pr[50]), 0);
      chk("db_n_at54", 32'(nr[54]), 0);
      chk("db_n_at55", 32'(nr[55]), 1);
      chk("db_n_at0",  32'(nr[0]), 0);
      chk("db_p_at4",  32'(pr[4]), 0);
      chk("db_p_at5",  32'(pr[5]), 1);

      // Extremes.
      per = 16'd9; db = 16'd2; duty = 16'd0; cnt = 16'd0;
      disable_pulse();
      run(12);
      chk("duty0_n", 32'(n), 1);
      chk("duty0_p", 32'(p), 0);
      duty = 16'd10;
      run(12);
      chk("dutymax_p", 32'(p), 1);
      duty = 16'hFFFF;
      run(12);
      chk("dutyffff_p", 32'(p), 1);
      hold = 1; cnt = 16'hFFFF; duty = 16'd5;
      run(12);
      chk("cnt_ones_n", 32'(n), 1);

      // Demand reversal inside an 8-cycle dead time.
      per = 16'd99; duty = 16'd50; db = 16'd8; cnt = 16'd40;
      run(20);
      chk("rev_pre_p", 32'(p), 1);
      cnt = 16'd60;
      tick(); chk("rev_e0_p", 32'(p), 0);
      tick();
      tick();
      cnt = 16'd10;
      for (int i = 3; i < 8; i++) begin
         tick();
         chk("rev_gap_p", 32'(p), 0);
         chk("rev_gap_n", 32'(n), 0);
      end
      tick();
      chk("rev_end_p", 32'(p), 1);

      // Randomised duty / dead time / period with occasional disables.
      hold = 0; cnt = 16'd0;
      for (int i = 0; i < 10000; i++) begin
         if (cnt == 16'd0) begin
            per  = 16'($urandom_range(60, 10));
            duty = ($urandom_range(9, 0) == 0) ? 16'hFFFF :
                   16'($urandom_range(int'(per) + 2, 0));
            db   = 16'($urandom_range(6, 0));
         end
         if ($urandom_range(399, 0) == 0) disable_pulse();
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
